fetch_queue_unit: RTL and testbench

- Parametrised instruction-fetch front end for the RISC-V core. Generalises the single-register PC, PC+4 adder and branch/jump PC muxes into one block.
- Holds the fetch PC and issues requests to a synchronous instruction memory with a fixed 1-cycle read latency.
- Buffers returned instructions in a QDEPTH-entry prefetch queue with a valid/ready handshake to decode.
- Accepts one merged redirect (taken branch or jump) from execute, which flushes wrong-path state.

---
 rtl/fetch_queue_unit_if.sv | 32 +++
 rtl/fetch_queue_unit.sv | 180 ++++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if
//   Groups the buses of the instruction-fetch front end:
//     - instruction memory request/response (imem_req, imem_addr, imem_rdata)
//     - redirect from execute (redirect_valid, redirect_target)
//     - decode-side valid/ready handshake (out_valid, out_ready, out_instr,
//       out_pc, out_pc4)
//   modport master : the fetch unit side
//   modport slave  : the environment side (memory, execute, decode)
interface fetch_queue_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc4;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    input  imem_rdata, redirect_valid, redirect_target, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc4,
    output imem_rdata, redirect_valid, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction-fetch front end: holds the fetch PC, issues requests to a
//   synchronous instruction memory (1-cycle read latency), buffers returned
//   instructions in a QDEPTH-entry prefetch queue and presents them to decode
//   with a valid/ready handshake. A redirect from execute flushes all
//   wrong-path state and restarts fetch at the target.
//
// Parameters
//   XLEN     : PC / address / instruction width
//   QDEPTH   : prefetch queue entries (power of two, >= 2)
//   RESET_PC : first byte address fetched after reset
//
// Ports
//   clk         : clock, rising edge
//   reset       : synchronous, active-low
//   bus         : fetch_queue_unit_if.master (imem, redirect, decode buses)
//   fetch_fault : (FETCH_ALIGN_CHECK_EN only) misaligned redirect seen
//   fault_addr  : (FETCH_ALIGN_CHECK_EN only) offending redirect target
//
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   Defined   : a redirect with target[1:0] != 0 flushes and parks the unit in
//               FAULT until reset.
//   Undefined : target[1:0] is ignored (forced to 00).
module fetch_queue_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  fetch_queue_unit_if.master  bus
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                fetch_fault,
  output logic [XLEN-1:0]     fault_addr
`endif
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] QDEPTH_W = (CW+1)'(QDEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_FETCH,
    ST_FAULT
  } state_t;

  state_t state, state_next;

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic [XLEN-1:0] q_instr [QDEPTH];
  logic [XLEN-1:0] q_pc    [QDEPTH];

  logic            issue;
  logic            head_valid;
  logic            deq;
  logic            enq;
  logic            flush;
  logic [CW:0]     credit;
  logic [XLEN-1:0] target_aligned;

  assign target_aligned = bus.redirect_target & ALIGN_MASK;

`ifdef FETCH_ALIGN_CHECK_EN
  logic            misaligned;
  logic            fault_entry;
  logic [XLEN-1:0] fault_addr_q;

  assign misaligned  = bus.redirect_target[1:0] != 2'b00;
  assign fault_entry = (state != ST_FAULT) && (state_next == ST_FAULT);
`endif

  // Next state and per-cycle control. Redirect has top priority: it blocks
  // issue, discards the arriving response and hides the head from decode so
  // that a handshake in the redirect cycle is not a dequeue.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    head_valid = 1'b0;
    deq        = 1'b0;
    enq        = 1'b0;
    flush      = 1'b0;
    credit     = {1'b0, count} + (CW+1)'(inflight);
    unique case (state)
      ST_BOOT: begin
        state_next = ST_FETCH;
        flush      = bus.redirect_valid;
`ifdef FETCH_ALIGN_CHECK_EN
        if (bus.redirect_valid && misaligned) state_next = ST_FAULT;
`endif
      end
      ST_FETCH: begin
        flush      = bus.redirect_valid;
        head_valid = (count != '0) && !bus.redirect_valid;
        deq        = head_valid && bus.out_ready;
        // Credit counts queued entries plus the response still in flight,
        // less the entry leaving this cycle, so the queue can never overflow.
        issue      = !bus.redirect_valid &&
                     ((credit - (CW+1)'(deq)) < QDEPTH_W);
        enq        = inflight && !bus.redirect_valid;
`ifdef FETCH_ALIGN_CHECK_EN
        if (bus.redirect_valid && misaligned) state_next = ST_FAULT;
`endif
      end
      default: begin
        state_next = state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_BOOT;
      fetch_pc    <= RESET_PC & ALIGN_MASK;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (issue) inflight_pc <= fetch_pc;
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        fetch_pc <= target_aligned;
      end else begin
        if (issue) fetch_pc <= fetch_pc + XLEN'(4);
        if (enq)   wr_ptr   <= wr_ptr + PW'(1);
        if (deq)   rd_ptr   <= rd_ptr + PW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end

  // Queue storage carries no reset; only entries below count are ever read
  // as valid.
  always_ff @(posedge clk) begin
    if (reset && enq) begin
      q_instr[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]    <= inflight_pc;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      fault_addr_q <= '0;
    end else if (fault_entry) begin
      fault_addr_q <= bus.redirect_target;
    end
  end

  always_comb begin
    fetch_fault = reset && (state == ST_FAULT);
    fault_addr  = reset ? fault_addr_q : '0;
  end
`endif

  // Every output is forced to zero while reset is held low, regardless of
  // the state registers still holding pre-reset values in that cycle.
  always_comb begin
    bus.imem_req  = reset && issue;
    bus.imem_addr = reset ? fetch_pc : '0;
    bus.out_valid = reset && head_valid;
    bus.out_instr = reset ? q_instr[rd_ptr] : '0;
    bus.out_pc    = reset ? q_pc[rd_ptr] : '0;
    bus.out_pc4   = reset ? (q_pc[rd_ptr] + XLEN'(4)) : '0;
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
module tb_fetch_queue_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0;
  logic rst1;
  int   n_pass;
  int   n_checks;

  fetch_queue_unit_if #(.XLEN(32)) bus0 ();
  fetch_queue_unit_if #(.XLEN(32)) bus1 ();

`ifdef FETCH_ALIGN_CHECK_EN
  logic        fault0, fault1;
  logic [31:0] faddr0, faddr1;
`endif

  fetch_queue_unit #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .reset(rst0), .bus(bus0)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_fault(fault0), .fault_addr(faddr0)
`endif
  );

  fetch_queue_unit #(.XLEN(32), .QDEPTH(4), .RESET_PC(32'h100)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_fault(fault1), .fault_addr(faddr1)
`endif
  );

  // Instruction memories: mem[a] = 0x1000 + a, one-cycle read latency.
  always @(posedge clk) if (bus0.imem_req) bus0.imem_rdata <= 32'h1000 + bus0.imem_addr;
  always @(posedge clk) if (bus1.imem_req) bus1.imem_rdata <= 32'h1000 + bus1.imem_addr;

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst0 = 1'b0; rst1 = 1'b0;
    bus0.out_ready = 1'b1; bus0.redirect_valid = 1'b0; bus0.redirect_target = '0;
    bus1.out_ready = 1'b1; bus1.redirect_valid = 1'b0; bus1.redirect_target = '0;
    repeat (2) next_cycle();
    #1;
    n_checks++; if (bus0.imem_req !== 1'b0) $display("FAIL reset_req got=%0h exp=0", bus0.imem_req); else n_pass++;
    n_checks++; if (bus0.out_valid !== 1'b0) $display("FAIL reset_valid got=%0h exp=0", bus0.out_valid); else n_pass++;
    n_checks++; if (bus0.imem_addr !== 32'h0) $display("FAIL reset_addr got=%0h exp=0", bus0.imem_addr); else n_pass++;
    n_checks++; if (bus0.out_pc4 !== 32'h0) $display("FAIL reset_pc4 got=%0h exp=0", bus0.out_pc4); else n_pass++;
  endtask

  task automatic test_boot_stream();
    logic [31:0] exp;
    next_cycle(); rst0 = 1'b1; #1;
    n_checks++; if (bus0.imem_req !== 1'b0) $display("FAIL boot_c0_req got=%0h exp=0", bus0.imem_req); else n_pass++;
    next_cycle(); #1;
    n_checks++; if (bus0.imem_req !== 1'b1) $display("FAIL boot_c1_req got=%0h exp=1", bus0.imem_req); else n_pass++;
    n_checks++; if (bus0.imem_addr !== 32'h0) $display("FAIL boot_c1_addr got=%0h exp=0", bus0.imem_addr); else n_pass++;
    next_cycle(); #1;
    n_checks++; if (bus0.out_valid !== 1'b0) $display("FAIL boot_c2_valid got=%0h exp=0", bus0.out_valid); else n_pass++;
    n_checks++; if (bus0.imem_addr !== 32'h4) $display("FAIL boot_c2_addr got=%0h exp=4", bus0.imem_addr); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      next_cycle(); #1;
      exp = 32'(i) * 32'd4;
      n_checks++; if (bus0.out_valid !== 1'b1) $display("FAIL stream_valid[%0d] got=%0h exp=1", i, bus0.out_valid); else n_pass++;
      n_checks++; if (bus0.out_pc !== exp) $display("FAIL stream_pc[%0d] got=%0h exp=%0h", i, bus0.out_pc, exp); else n_pass++;
      n_checks++; if (bus0.out_instr !== 32'h1000 + exp) $display("FAIL stream_instr[%0d] got=%0h exp=%0h", i, bus0.out_instr, 32'h1000 + exp); else n_pass++;
      n_checks++; if (bus0.out_pc4 !== exp + 32'd4) $display("FAIL stream_pc4[%0d] got=%0h exp=%0h", i, bus0.out_pc4, exp + 32'd4); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int          nreq;
    int          ngot;
    logic        last_req;
    logic [31:0] reqs [4];
    logic [31:0] got [8];
    nreq = 0; ngot = 0; last_req = 1'b1;
    for (int k = 0; k < 4; k++) reqs[k] = 32'hDEAD_BEEF;
    next_cycle(); rst0 = 1'b0; bus0.out_ready = 1'b0;
    next_cycle(); rst0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus0.imem_req) begin
        if (nreq < 4) reqs[nreq] = bus0.imem_addr;
        nreq++;
      end
      last_req = bus0.imem_req;
      next_cycle();
    end
    n_checks++; if (nreq !== 4) $display("FAIL bp_req_count got=%0d exp=4", nreq); else n_pass++;
    n_checks++; if ({reqs[0], reqs[1], reqs[2], reqs[3]} !== {32'h0, 32'h4, 32'h8, 32'hC})
      $display("FAIL bp_req_addrs got=%0h,%0h,%0h,%0h exp=0,4,8,c", reqs[0], reqs[1], reqs[2], reqs[3]); else n_pass++;
    n_checks++; if (last_req !== 1'b0) $display("FAIL bp_req_stalled got=%0h exp=0", last_req); else n_pass++;
    bus0.out_ready = 1'b1; #1;
    n_checks++; if (bus0.out_valid !== 1'b1) $display("FAIL bp_head_valid got=%0h exp=1", bus0.out_valid); else n_pass++;
    n_checks++; if (bus0.out_pc !== 32'h0) $display("FAIL bp_head_pc got=%0h exp=0", bus0.out_pc); else n_pass++;
    for (int c = 0; c < 40 && ngot < 8; c++) begin
      if (c > 0) begin next_cycle(); #1; end
      if (bus0.out_valid && bus0.out_ready) begin
        got[ngot] = bus0.out_pc;
        ngot++;
      end
    end
    n_checks++; if (ngot !== 8) $display("FAIL bp_drain_timeout got=%0d exp=8", ngot); else n_pass++;
    for (int k = 0; k < 8 && k < ngot; k++) begin
      n_checks++; if (got[k] !== 32'(k) * 32'd4) $display("FAIL bp_order[%0d] got=%0h exp=%0h", k, got[k], 32'(k) * 32'd4); else n_pass++;
    end
  endtask

  task automatic test_redirect();
    next_cycle(); bus0.redirect_valid = 1'b1; bus0.redirect_target = 32'h40; #1;
    n_checks++; if (bus0.out_valid !== 1'b0) $display("FAIL rd_t_valid got=%0h exp=0", bus0.out_valid); else n_pass++;
    n_checks++; if (bus0.imem_req !== 1'b0) $display("FAIL rd_t_req got=%0h exp=0", bus0.imem_req); else n_pass++;
    next_cycle(); bus0.redirect_valid = 1'b0; #1;
    n_checks++; if (bus0.out_valid !== 1'b0) $display("FAIL rd_t1_valid got=%0h exp=0", bus0.out_valid); else n_pass++;
    n_checks++; if ({bus0.imem_req, bus0.imem_addr} !== {1'b1, 32'h40}) $display("FAIL rd_t1_req got=%0h/%0h exp=1/40", bus0.imem_req, bus0.imem_addr); else n_pass++;
    next_cycle(); #1;
    n_checks++; if (bus0.out_valid !== 1'b0) $display("FAIL rd_t2_valid got=%0h exp=0", bus0.out_valid); else n_pass++;
    next_cycle(); #1;
    n_checks++; if (bus0.out_valid !== 1'b1) $display("FAIL rd_t3_valid got=%0h exp=1", bus0.out_valid); else n_pass++;
    n_checks++; if (bus0.out_pc !== 32'h40) $display("FAIL rd_t3_pc got=%0h exp=40", bus0.out_pc); else n_pass++;
    n_checks++; if (bus0.out_pc4 !== 32'h44) $display("FAIL rd_t3_pc4 got=%0h exp=44", bus0.out_pc4); else n_pass++;
    n_checks++; if (bus0.out_instr !== 32'h1040) $display("FAIL rd_t3_instr got=%0h exp=1040", bus0.out_instr); else n_pass++;
    next_cycle(); #1;
    n_checks++; if (bus0.out_pc !== 32'h44) $display("FAIL rd_t4_pc got=%0h exp=44", bus0.out_pc); else n_pass++;
  endtask

  task automatic test_full_redirect_wrap();
    next_cycle(); rst0 = 1'b0; bus0.out_ready = 1'b0;
    next_cycle(); rst0 = 1'b1;
    repeat (8) next_cycle();
    #1;
    n_checks++; if ({bus0.out_valid, bus0.imem_req} !== 2'b10) $display("FAIL full_state got=%0h/%0h exp=1/0", bus0.out_valid, bus0.imem_req); else n_pass++;
    next_cycle(); bus0.out_ready = 1'b1; bus0.redirect_valid = 1'b1; bus0.redirect_target = 32'hFFFF_FFFC; #1;
    n_checks++; if ({bus0.out_valid, bus0.imem_req} !== 2'b00) $display("FAIL fr_t_out got=%0h/%0h exp=0/0", bus0.out_valid, bus0.imem_req); else n_pass++;
    next_cycle(); bus0.redirect_valid = 1'b0; #1;
    n_checks++; if (bus0.out_valid !== 1'b0) $display("FAIL fr_flushed got=%0h exp=0", bus0.out_valid); else n_pass++;
    n_checks++; if ({bus0.imem_req, bus0.imem_addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL fr_t1_req got=%0h/%0h exp=1/fffffffc", bus0.imem_req, bus0.imem_addr); else n_pass++;
    next_cycle(); #1;
    n_checks++; if ({bus0.imem_req, bus0.imem_addr} !== {1'b1, 32'h0}) $display("FAIL fr_wrap_addr got=%0h/%0h exp=1/0", bus0.imem_req, bus0.imem_addr); else n_pass++;
    next_cycle(); #1;
    n_checks++; if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL fr_t3_pc got=%0h/%0h exp=1/fffffffc", bus0.out_valid, bus0.out_pc); else n_pass++;
    n_checks++; if (bus0.out_pc4 !== 32'h0) $display("FAIL fr_t3_pc4 got=%0h exp=0", bus0.out_pc4); else n_pass++;
    n_checks++; if (bus0.out_instr !== 32'h0000_0FFC) $display("FAIL fr_t3_instr got=%0h exp=ffc", bus0.out_instr); else n_pass++;
    next_cycle(); #1;
    n_checks++; if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'h0}) $display("FAIL fr_t4_pc got=%0h/%0h exp=1/0", bus0.out_valid, bus0.out_pc); else n_pass++;
    n_checks++; if (bus0.out_instr !== 32'h1000) $display("FAIL fr_t4_instr got=%0h exp=1000", bus0.out_instr); else n_pass++;
  endtask

  task automatic test_misaligned_redirect();
    next_cycle(); bus0.redirect_valid = 1'b1; bus0.redirect_target = 32'h22; #1;
    n_checks++; if (bus0.out_valid !== 1'b0) $display("FAIL mis_t_valid got=%0h exp=0", bus0.out_valid); else n_pass++;
    next_cycle(); bus0.redirect_valid = 1'b0; #1;
`ifdef FETCH_ALIGN_CHECK_EN
    n_checks++; if (fault0 !== 1'b1) $display("FAIL mis_fault got=%0h exp=1", fault0); else n_pass++;
    n_checks++; if (faddr0 !== 32'h22) $display("FAIL mis_fault_addr got=%0h exp=22", faddr0); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({bus0.imem_req, bus0.out_valid, fault0} !== 3'b001) $display("FAIL mis_parked[%0d] got=%0h/%0h/%0h exp=0/0/1", i, bus0.imem_req, bus0.out_valid, fault0); else n_pass++;
      next_cycle(); #1;
    end
    next_cycle(); rst0 = 1'b0; #1;
    n_checks++; if ({fault0, faddr0} !== 33'h0) $display("FAIL mis_reset got=%0h/%0h exp=0/0", fault0, faddr0); else n_pass++;
    next_cycle(); rst0 = 1'b1; next_cycle(); #1;
    n_checks++; if ({bus0.imem_req, bus0.imem_addr, fault0} !== {1'b1, 32'h0, 1'b0}) $display("FAIL mis_restart got=%0h/%0h/%0h exp=1/0/0", bus0.imem_req, bus0.imem_addr, fault0); else n_pass++;
`else
    n_checks++; if ({bus0.imem_req, bus0.imem_addr} !== {1'b1, 32'h20}) $display("FAIL mis_t1_req got=%0h/%0h exp=1/20", bus0.imem_req, bus0.imem_addr); else n_pass++;
    next_cycle(); next_cycle(); #1;
    n_checks++; if ({bus0.out_valid, bus0.out_pc} !== {1'b1, 32'h20}) $display("FAIL mis_t3_pc got=%0h/%0h exp=1/20", bus0.out_valid, bus0.out_pc); else n_pass++;
    n_checks++; if (bus0.out_instr !== 32'h1020) $display("FAIL mis_t3_instr got=%0h exp=1020", bus0.out_instr); else n_pass++;
`endif
  endtask

  task automatic test_reset_midstream();
    next_cycle(); rst1 = 1'b1; #1;
    n_checks++; if (bus1.imem_req !== 1'b0) $display("FAIL rp_c0_req got=%0h exp=0", bus1.imem_req); else n_pass++;
    next_cycle(); #1;
    n_checks++; if ({bus1.imem_req, bus1.imem_addr} !== {1'b1, 32'h100}) $display("FAIL rp_c1_req got=%0h/%0h exp=1/100", bus1.imem_req, bus1.imem_addr); else n_pass++;
    next_cycle(); next_cycle(); #1;
    n_checks++; if ({bus1.out_valid, bus1.out_pc} !== {1'b1, 32'h100}) $display("FAIL rp_c3_pc got=%0h/%0h exp=1/100", bus1.out_valid, bus1.out_pc); else n_pass++;
    repeat (3) next_cycle();
    next_cycle(); rst1 = 1'b0; #1;
    n_checks++; if ({bus1.imem_req, bus1.out_valid} !== 2'b00) $display("FAIL mr_ctrl got=%0h/%0h exp=0/0", bus1.imem_req, bus1.out_valid); else n_pass++;
    n_checks++; if (bus1.imem_addr !== 32'h0) $display("FAIL mr_addr got=%0h exp=0", bus1.imem_addr); else n_pass++;
    n_checks++; if ({bus1.out_pc, bus1.out_pc4, bus1.out_instr} !== 96'h0) $display("FAIL mr_data got=%0h/%0h/%0h exp=0/0/0", bus1.out_pc, bus1.out_pc4, bus1.out_instr); else n_pass++;
    next_cycle(); rst1 = 1'b1; #1;
    n_checks++; if ({bus1.imem_req, bus1.out_valid} !== 2'b00) $display("FAIL mr_c0 got=%0h/%0h exp=0/0", bus1.imem_req, bus1.out_valid); else n_pass++;
    next_cycle(); #1;
    n_checks++; if ({bus1.imem_req, bus1.imem_addr, bus1.out_valid} !== {1'b1, 32'h100, 1'b0}) $display("FAIL mr_c1 got=%0h/%0h/%0h exp=1/100/0", bus1.imem_req, bus1.imem_addr, bus1.out_valid); else n_pass++;
    next_cycle(); #1;
    n_checks++; if (bus1.out_valid !== 1'b0) $display("FAIL mr_c2_valid got=%0h exp=0", bus1.out_valid); else n_pass++;
    next_cycle(); #1;
    n_checks++; if ({bus1.out_valid, bus1.out_pc} !== {1'b1, 32'h100}) $display("FAIL mr_c3_pc got=%0h/%0h exp=1/100", bus1.out_valid, bus1.out_pc); else n_pass++;
    n_checks++; if (bus1.out_instr !== 32'h1100) $display("FAIL mr_c3_instr got=%0h exp=1100", bus1.out_instr); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    test_reset();
    test_boot_stream();
    test_backpressure();
    test_redirect();
    test_full_redirect_wrap();
    test_misaligned_redirect();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
